// File: rtl/mem_bus_master.sv
// mem_bus_master: single-request initiator for the shared addr/re/we/data_bus memory.
// Define MEM_BUS_TURNAROUND_EN to insert a dead TURN cycle after each bus transaction.
module mem_bus_master #(
   parameter int ADDR_SIZE = 4,
   parameter int WIDTH     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic                 i_req_we,
   input  logic [ADDR_SIZE-1:0] i_req_addr,
   input  logic [WIDTH-1:0]     i_req_wdata,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [WIDTH-1:0]     o_rsp_rdata,
   output logic [ADDR_SIZE-1:0] o_mem_addr,
   output logic                 o_mem_re,
   output logic                 o_mem_we,
   inout  wire  [WIDTH-1:0]     io_data_bus
);
`ifdef MEM_BUS_TURNAROUND_EN
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP, S_TURN} state_t;
   localparam state_t S_NEXT = S_TURN;
   localparam logic READY_NEXT = 1'b0;
`else
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;
   localparam state_t S_NEXT = S_IDLE;
   localparam logic READY_NEXT = 1'b1;
`endif
   state_t           r_state;
   logic [WIDTH-1:0] r_wdata;
   logic             r_drive;
   // Driver enable is its own flop so async reset releases the bus at once.
   assign io_data_bus = r_drive ? r_wdata : {WIDTH{1'bz}};
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         o_req_ready <= 1'b1;
         o_rsp_valid <= 1'b0;
         o_mem_re    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_rsp_rdata <= '0;
         r_wdata     <= '0;
         r_drive     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_req_valid) begin
               r_state     <= i_req_we ? S_WRITE : S_READ;
               o_req_ready <= 1'b0;
               o_mem_we    <= i_req_we;
               o_mem_re    <= !i_req_we;
               r_drive     <= i_req_we;
               o_mem_addr  <= i_req_addr;
               r_wdata     <= i_req_wdata;
            end
            S_WRITE: begin
               r_state     <= S_NEXT;
               o_req_ready <= READY_NEXT;
               o_mem_we    <= 1'b0;
               r_drive     <= 1'b0;
            end
            S_READ: begin
               r_state     <= S_RESP;
               o_mem_re    <= 1'b0;
               o_rsp_valid <= 1'b1;
               o_rsp_rdata <= io_data_bus;
            end
            S_RESP: if (i_rsp_ready) begin
               r_state     <= S_NEXT;
               o_req_ready <= READY_NEXT;
               o_rsp_valid <= 1'b0;
            end
`ifdef MEM_BUS_TURNAROUND_EN
            S_TURN: begin
               r_state     <= S_IDLE;
               o_req_ready <= 1'b1;
            end
`endif
            default: begin
               r_state     <= S_IDLE;
               o_req_ready <= 1'b1;
               o_rsp_valid <= 1'b0;
               o_mem_re    <= 1'b0;
               o_mem_we    <= 1'b0;
               r_drive     <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed and random requests against a bus memory model and a
// latency-rule reference model checked every cycle.
module tb_mem_bus_master;
`ifdef MEM_BUS_TURNAROUND_EN
   localparam int TA = 1;
`else
   localparam int TA = 0;
`endif
   logic       clk = 0, rst_n = 0, req_valid = 0, req_we = 0, rsp_ready = 1;
   logic [3:0] req_addr = 0;
   logic [7:0] req_wdata = 0;
   logic       req_ready, rsp_valid, mem_re, mem_we;
   logic [7:0] rsp_rdata;
   logic [3:0] mem_addr;
   wire  [7:0] data_bus;
   int         n_chk = 0, n_pass = 0, cyc = 0, we_prev = 0, we_last = 0;
   bit         rnd = 0;
   always #5 clk = ~clk;
   mem_bus_master #(.ADDR_SIZE(4), .WIDTH(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_mem_addr(mem_addr), .o_mem_re(mem_re), .o_mem_we(mem_we), .io_data_bus(data_bus));
   // Memory slave; when neither strobe is up the bench parks the bus at 0 so a stray master drive shows.
   logic [7:0] mem [16];
   assign data_bus = mem_re ? mem[mem_addr] : (mem_we ? 8'bz : 8'h00);
   always @(posedge clk) if (mem_we) mem[mem_addr] <= data_bus;
   // Reference model: one outstanding transaction described by its accept and handshake cycles.
   logic [7:0] ref_mem [16];
   int         m_kind = 0, m_acc = 0, m_hs = 0;
   bit         m_hs_done = 0;
   logic [3:0] m_addr = 0;
   logic [7:0] m_wdata = 0, m_exp = 0;
   function automatic bit e_we(int n); return m_kind == 1 && n == m_acc + 1; endfunction
   function automatic bit e_re(int n); return m_kind == 2 && n == m_acc + 1; endfunction
   function automatic bit e_rv(int n); return m_kind == 2 && n >= m_acc + 2 && !m_hs_done; endfunction
   function automatic bit e_ready(int n);
      return m_kind == 0 || (m_kind == 1 && n >= m_acc + 2 + TA) ||
             (m_kind == 2 && m_hs_done && n >= m_hs + 1 + TA);
   endfunction
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_kind = 0; m_addr = 0; m_hs_done = 0;
      end else begin
         if (e_we(cyc)) ref_mem[m_addr] = m_wdata;
         if (e_rv(cyc) && rsp_ready) begin m_hs = cyc; m_hs_done = 1; end
         if (e_ready(cyc) && req_valid) begin
            m_kind = req_we ? 1 : 2; m_acc = cyc; m_addr = req_addr; m_wdata = req_wdata;
            m_hs_done = 0;
            if (!req_we) m_exp = ref_mem[req_addr];
         end
         cyc++;
      end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask
   always @(negedge clk)
      if (!rst_n) begin
         chk("rst_req_ready", 32'(req_ready), 32'd1);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_mem_re", 32'(mem_re), 32'd0);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_mem_addr", 32'(mem_addr), 32'd0);
         chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      end else begin
         chk("req_ready", 32'(req_ready), 32'(e_ready(cyc)));
         chk("mem_we", 32'(mem_we), 32'(e_we(cyc)));
         chk("mem_re", 32'(mem_re), 32'(e_re(cyc)));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv(cyc)));
         chk("mem_addr", 32'(mem_addr), 32'(m_addr));
         chk("no_re_we", 32'(mem_re & mem_we), 32'd0);
         if (e_we(cyc)) chk("write_bus", 32'(data_bus), 32'(m_wdata));
         if (e_rv(cyc)) chk("rsp_rdata", 32'(rsp_rdata), 32'(m_exp));
         if (!e_we(cyc) && !e_re(cyc)) chk("bus_released", 32'(data_bus), 32'd0);
         if (mem_we) begin we_prev = we_last; we_last = cyc; end
      end
   task automatic do_req(input logic we, input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin
            @(posedge clk); #1;
            req_valid = 0;
            return;
         end
         @(negedge clk);
      end
      n_chk++;
      $display("FAIL req_accept: not accepted within 50 cycles (addr %0h)", a);
      req_valid = 0;
   endtask
   task automatic wait_rsp();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rsp_valid) return;
      end
      n_chk++;
      $display("FAIL rsp_wait: rsp_valid not seen within 30 cycles");
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i] = 8'(i * 29 + 7);
         ref_mem[i] = 8'(i * 29 + 7);
      end
      repeat (3) @(negedge clk);
      rst_n = 1;
      do_req(1, 4'h3, 8'hA5);
      @(negedge clk);
      chk("wr3_we", 32'(mem_we), 32'd1);
      chk("wr3_bus", 32'(data_bus), 32'hA5);
      @(negedge clk);
      chk("wr3_we_off", 32'(mem_we), 32'd0);
      chk("wr3_ready", 32'(req_ready), 32'(TA == 0));
      chk("wr3_mem", 32'(mem[3]), 32'hA5);
      do_req(1, 4'h7, 8'h5C);
      do_req(0, 4'h7, 8'h00);
      wait_rsp();
      chk("raw_rdata", 32'(rsp_rdata), 32'h5C);
      @(negedge clk);
      chk("raw_rv_once", 32'(rsp_valid), 32'd0);
      rsp_ready = 0;
      do_req(0, 4'h3, 8'h00);
      fork
         begin repeat (6) @(negedge clk); rsp_ready = 1; end
         begin
            wait_rsp();
            repeat (3) begin
               chk("bp_rdata", 32'(rsp_rdata), 32'hA5);
               chk("bp_ready", 32'(req_ready), 32'd0);
               @(negedge clk);
            end
         end
         do_req(1, 4'h9, 8'h42);
      join
      do_req(1, 4'hE, 8'h77);
      #2 rst_n = 0;
      #1;
      chk("arst_mem_we", 32'(mem_we), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      chk("arst_mem_addr", 32'(mem_addr), 32'd0);
      chk("arst_bus", 32'(data_bus), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      do_req(0, 4'hE, 8'h00);
      wait_rsp();
      chk("abort_rdata", 32'(rsp_rdata), 32'h9D);
      do_req(1, 4'h1, 8'h11);
      do_req(1, 4'h2, 8'h22);
      repeat (4) @(negedge clk);
      chk("b2b_gap", 32'(we_last - we_prev), 32'(2 + TA));
      rnd = 1;
      fork
         while (rnd) begin @(negedge clk); rsp_ready = 1'($urandom_range(0, 1)); end
      join_none
      for (int i = 0; i < 200; i++)
         do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      rnd = 0;
      @(negedge clk); #1;
      rsp_ready = 1;
      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
